// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result collector: record layout, FSM encoding
// and the record builder used at capture time.
package tdc_pkg;

  localparam int REC_W     = 48;
  localparam int REC_BYTES = 6;
  localparam int COARSE_W  = 32;
  localparam int FINE_W    = 9;
  localparam int SEQ_W     = 6;

  localparam logic [FINE_W-1:0] FINE_MAX = 9'd286;

  // Record layout, MSB first: {seq, sat, fine_c, coarse}
  localparam int COARSE_LSB = 0;
  localparam int FINE_LSB   = 32;
  localparam int SAT_BIT    = 41;
  localparam int SEQ_LSB    = 42;

  localparam logic [7:0] READ_EMPTY_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  function automatic logic [REC_W-1:0] build_record(
    input logic [SEQ_W-1:0]    seq,
    input logic [FINE_W-1:0]   fine,
    input logic [COARSE_W-1:0] coarse,
    input logic [FINE_W-1:0]   fine_max
  );
    logic              sat;
    logic [FINE_W-1:0] fine_c;
    logic [REC_W-1:0]  rec;
    sat    = (fine > fine_max);
    fine_c = sat ? fine_max : fine;
    rec                           = '0;
    rec[COARSE_LSB +: COARSE_W]   = coarse;
    rec[FINE_LSB +: FINE_W]       = fine_c;
    rec[SAT_BIT]                  = sat;
    rec[SEQ_LSB +: SEQ_W]         = seq;
    return rec;
  endfunction

endpackage

// File: rtl/tdc_rec_fifo.sv
// Register-based show-ahead FIFO for measurement records. A push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module tdc_rec_fifo
  import tdc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = REC_W,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
      else if (w_do_pop && !w_do_push) r_level <= r_level - LW'(1);
    end
  end

  // Storage carries no reset; only slots behind a valid pointer are ever read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/tdc_result_collector.sv
// Collects completed TDC measurements into tagged 48-bit records, queues them
// and serves them to the SPI front end one byte at a time, MSB byte first.
module tdc_result_collector
  import tdc_pkg::*;
#(
  parameter int                DEPTH     = 8,
  parameter logic [FINE_W-1:0] FINE_MAX  = tdc_pkg::FINE_MAX,
  parameter int                REC_BYTES = tdc_pkg::REC_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_tdc_busy,
  input  logic [31:0] i_tdc_coarse,
  input  logic [8:0]  i_tdc_fine,
  input  logic        i_byte_rd,
  output logic [7:0]  o_byte_data,
  output logic        o_byte_valid,
  output logic        o_rec_avail,
  output logic [3:0]  o_fifo_level,
  output logic        o_overflow,
  input  logic        i_clr_ovf
);

  localparam int         LW       = $clog2(DEPTH) + 1;
  localparam logic [2:0] LAST_IDX = 3'(REC_BYTES - 1);

  logic             r_busy_meta;
  logic             r_busy_sync;
  logic             r_busy_q;
  logic             w_rise;
  logic             w_fall;
  cap_state_t       r_state;
  cap_state_t       w_next_state;
  logic [SEQ_W-1:0] r_seq;
  logic [2:0]       r_idx;
  logic             r_overflow;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [REC_W-1:0] w_record;
  logic [REC_W-1:0] w_head;
  logic [REC_W-1:0] w_head_shifted;
  logic [7:0]       w_head_byte;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [LW-1:0]    w_level;

  // Busy comes from start/stop edges in another domain: two flops, then edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_meta <= 1'b0;
      r_busy_sync <= 1'b0;
      r_busy_q    <= 1'b0;
    end else begin
      r_busy_meta <= i_tdc_busy;
      r_busy_sync <= r_busy_meta;
      r_busy_q    <= r_busy_sync;
    end
  end

  assign w_rise = ~r_busy_q & r_busy_sync;
  assign w_fall = r_busy_q & ~r_busy_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rise && i_enable) w_next_state = ARMED;
      ARMED: begin
        if (!i_enable)   w_next_state = IDLE;
        else if (w_fall) w_next_state = CAPTURE;
      end
      CAPTURE: w_next_state = (w_rise && i_enable) ? ARMED : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_push   = (r_state == CAPTURE);
  assign w_record = build_record(r_seq, i_tdc_fine, i_tdc_coarse, FINE_MAX);
  assign w_pop    = i_byte_rd & ~w_fifo_empty & (r_idx == LAST_IDX);
  assign w_drop   = w_push & w_fifo_full & ~w_pop;

  tdc_rec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_record),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  // The sequence number also advances for dropped records so gaps are visible downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_seq <= '0;
    else if (w_push) r_seq <= r_seq + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (i_clr_ovf) r_overflow <= 1'b0;
  end

  assign w_head_shifted = w_head << {r_idx, 3'b000};
  assign w_head_byte    = w_head_shifted[REC_W-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_data  <= 8'h00;
      r_byte_valid <= 1'b0;
      r_idx        <= 3'd0;
    end else begin
      r_byte_valid <= i_byte_rd;
      if (i_byte_rd) begin
        if (!w_fifo_empty) begin
          r_byte_data <= w_head_byte;
          r_idx       <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end else begin
          r_byte_data <= READ_EMPTY_BYTE;
        end
      end
    end
  end

  assign o_byte_data  = r_byte_data;
  assign o_byte_valid = r_byte_valid;
  assign o_rec_avail  = ~w_fifo_empty;
  assign o_fifo_level = 4'(w_level);
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_tdc_result_collector.sv
// Self-checking bench for tdc_result_collector: table-driven captures plus
// hand-written overflow, empty-read, simultaneous push/pop and reset sequences.
module tb_tdc_result_collector;
  import tdc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy;
  logic [31:0] coarse;
  logic [8:0]  fine;
  logic        byte_rd;
  logic        clr_ovf;
  logic [7:0]  o_byte_data;
  logic        o_byte_valid;
  logic        o_rec_avail;
  logic [3:0]  o_fifo_level;
  logic        o_overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [47:0] modelRecs[$];
  logic [7:0]  expBytes[$];
  int          modelIdx = 0;
  logic [5:0]  modelSeq = '0;
  logic        expOvf = 1'b0;
  logic        rdSeen = 1'b0;

  typedef struct {
    logic [31:0] coarse;
    logic [8:0]  fine;
    logic        expSat;
    logic [8:0]  expFineC;
  } vec_t;

  vec_t vecs[6];

  tdc_result_collector #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (enable),
    .i_tdc_busy   (busy),
    .i_tdc_coarse (coarse),
    .i_tdc_fine   (fine),
    .i_byte_rd    (byte_rd),
    .o_byte_data  (o_byte_data),
    .o_byte_valid (o_byte_valid),
    .o_rec_avail  (o_rec_avail),
    .o_fifo_level (o_fifo_level),
    .o_overflow   (o_overflow),
    .i_clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) rdSeen <= byte_rd;

  // Scoreboard: one byte_valid exactly one cycle after each byte_rd, data from the queue.
  always @(negedge clk) begin
    if (!rst && (rdSeen || o_byte_valid)) begin
      checkOutput("byte_valid_latency", {47'd0, o_byte_valid}, {47'd0, rdSeen});
      if (o_byte_valid) begin
        if (expBytes.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", o_byte_data);
        end else begin
          logic [7:0] e;
          e = expBytes.pop_front();
          checkOutput("byte_data", {40'd0, o_byte_data}, {40'd0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic satOf(input logic [8:0] f);
    return (f > 9'd286);
  endfunction

  function automatic logic [8:0] fineCOf(input logic [8:0] f);
    return (f > 9'd286) ? 9'd286 : f;
  endfunction

  task automatic modelCapture(input logic [31:0] c, input logic s, input logic [8:0] fc);
    logic [47:0] rec;
    rec = {modelSeq, s, fc, c};
    if (modelRecs.size() < 8) modelRecs.push_back(rec);
    else expOvf = 1'b1;
    modelSeq = modelSeq + 6'd1;
  endtask

  task automatic modelRead();
    logic [47:0] rec;
    if (modelRecs.size() > 0) begin
      rec = modelRecs[0];
      expBytes.push_back(rec[47 - 8*modelIdx -: 8]);
      modelIdx++;
      if (modelIdx == 6) begin
        void'(modelRecs.pop_front());
        modelIdx = 0;
      end
    end else begin
      expBytes.push_back(8'hFF);
    end
  endtask

  // Leaves busy freshly deasserted just after a rising edge.
  task automatic pulseBusy(input logic [31:0] c, input logic [8:0] f);
    coarse = c;
    fine   = f;
    tick();
    busy = 1'b1;
    repeat (4) tick();
    busy = 1'b0;
  endtask

  task automatic measure(input logic [31:0] c, input logic [8:0] f, input logic s, input logic [8:0] fc);
    pulseBusy(c, f);
    modelCapture(c, s, fc);
    repeat (6) tick();
  endtask

  task automatic readBytes(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      byte_rd = 1'b1;
      modelRead();
    end
    tick();
    byte_rd = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    measure(v.coarse, v.fine, v.expSat, v.expFineC);
    checkOutput("level_after_capture", {44'd0, o_fifo_level}, 48'(modelRecs.size()));
    checkOutput("rec_avail_after_capture", {47'd0, o_rec_avail}, 48'd1);
    readBytes(6);
    checkOutput("level_after_read", {44'd0, o_fifo_level}, 48'd0);
    checkOutput("rec_avail_after_read", {47'd0, o_rec_avail}, 48'd0);
  endtask

  initial begin
    vecs[0] = '{coarse: 32'd5,          fine: 9'd100, expSat: 1'b0, expFineC: 9'd100};
    vecs[1] = '{coarse: 32'd5,          fine: 9'd300, expSat: 1'b1, expFineC: 9'd286};
    vecs[2] = '{coarse: 32'hDEADBEEF,   fine: 9'd286, expSat: 1'b0, expFineC: 9'd286};
    vecs[3] = '{coarse: 32'h00000000,   fine: 9'd287, expSat: 1'b1, expFineC: 9'd286};
    vecs[4] = '{coarse: 32'hFFFFFFFF,   fine: 9'd511, expSat: 1'b1, expFineC: 9'd286};
    vecs[5] = '{coarse: 32'h12345678,   fine: 9'd0,   expSat: 1'b0, expFineC: 9'd0};

    rst = 1'b1; enable = 1'b0; busy = 1'b0; coarse = '0; fine = '0;
    byte_rd = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_byte_data",  {40'd0, o_byte_data},  48'd0);
    checkOutput("reset_byte_valid", {47'd0, o_byte_valid}, 48'd0);
    checkOutput("reset_rec_avail",  {47'd0, o_rec_avail},  48'd0);
    checkOutput("reset_fifo_level", {44'd0, o_fifo_level}, 48'd0);
    checkOutput("reset_overflow",   {47'd0, o_overflow},   48'd0);
    rst = 1'b0;
    tick();
    enable = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Read while empty returns the filler byte and must not advance the byte index.
    readBytes(1);
    measure(32'hCAFE0001, 9'd7, 1'b0, 9'd7);
    readBytes(6);

    // Nine captures with no reads: eight stored, one dropped.
    for (int i = 0; i < 9; i++) begin
      logic [8:0] f;
      f = 9'(i * 40);
      measure(32'h1000 + 32'(i), f, satOf(f), fineCOf(f));
    end
    checkOutput("full_level",     {44'd0, o_fifo_level}, 48'd8);
    checkOutput("full_overflow",  {47'd0, o_overflow},   {47'd0, expOvf});
    checkOutput("full_rec_avail", {47'd0, o_rec_avail},  48'd1);
    tick();
    clr_ovf = 1'b1;
    expOvf = 1'b0;
    tick();
    clr_ovf = 1'b0;
    checkOutput("clr_ovf_clears", {47'd0, o_overflow}, 48'd0);

    // Last byte of the head record read in the very cycle the FSM is in CAPTURE.
    readBytes(5);
    pulseBusy(32'hABCD0123, 9'd50);
    repeat (3) tick();
    byte_rd = 1'b1;
    modelRead();
    modelCapture(32'hABCD0123, 1'b0, 9'd50);
    tick();
    byte_rd = 1'b0;
    repeat (3) tick();
    checkOutput("pushpop_level",    {44'd0, o_fifo_level}, 48'(modelRecs.size()));
    checkOutput("pushpop_overflow", {47'd0, o_overflow},   {47'd0, expOvf});
    readBytes(48);
    checkOutput("drained_level", {44'd0, o_fifo_level}, 48'd0);

    // Reset in the middle of a record.
    measure(32'h55AA55AA, 9'd200, 1'b0, 9'd200);
    readBytes(3);
    rst = 1'b1;
    modelRecs.delete();
    modelIdx = 0;
    modelSeq = '0;
    expOvf   = 1'b0;
    tick();
    checkOutput("midrec_reset_level",     {44'd0, o_fifo_level}, 48'd0);
    checkOutput("midrec_reset_rec_avail", {47'd0, o_rec_avail},  48'd0);
    checkOutput("midrec_reset_byte_data", {40'd0, o_byte_data},  48'd0);
    checkOutput("midrec_reset_overflow",  {47'd0, o_overflow},   48'd0);
    rst = 1'b0;
    tick();

    // Enable drops while ARMED: the measurement must be discarded.
    busy = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    repeat (2) tick();
    busy = 1'b0;
    repeat (6) tick();
    enable = 1'b1;
    checkOutput("disarm_no_push", {44'd0, o_fifo_level}, 48'd0);

    // Sequence numbering restarts at zero after reset.
    measure(32'h00000042, 9'd1, 1'b0, 9'd1);
    readBytes(6);

    repeat (3) tick();
    checkOutput("scoreboard_drained", 48'(expBytes.size()), 48'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
